// File: rtl/mc_pkg.sv
// Shared constants for the multicycle controller: opcodes, state encoding, mux selects.
// Also defines the control-word struct that the output decoder drives.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BEQ      = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b10;
    localparam logic [1:0] ALUOP_FUNCT = 2'b01;

    localparam logic [1:0] ALUB_RT      = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts cycles spent waiting on memory; raises a sticky timeout at MEM_WAIT_MAX.
// Counter restarts on every FSM state change and saturates at the limit.
module mc_wait_timer #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    input  logic restart,
    output logic timeout
);

    localparam logic [7:0] LIMIT = 8'(MEM_WAIT_MAX);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= 8'd0;
            timeout <= 1'b0;
        end else begin
            if (restart) begin
                count <= 8'd0;
            end else if (waiting && (count != LIMIT)) begin
                count <= count + 8'd1;
            end
            // Set on the same edge the count lands on the limit.
            if (!restart && waiting && (count == LIMIT - 8'd1)) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main sequencing FSM for the multicycle MIPS-subset CPU; Moore outputs with a few
// mem_ready/zero/opcode-qualified strobes. Memory states stall until mem_ready.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       pcwrite,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;
    logic   waiting;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPE_EX;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWR:    if (mem_ready) state_d = S_FETCH;
            S_RTYPE_EX: state_d = S_RTYPE_WB;
            S_RTYPE_WB: state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_ADDI_WB:  state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ctrl = '0;
        unique case (state_q)
            S_FETCH: begin
                ctrl.mem_req = 1'b1;
                ctrl.alusrcb = ALUB_FOUR;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.pcsrc   = PCSRC_ALU;
                ctrl.irwrite = mem_ready;
                ctrl.pcwrite = mem_ready;
            end
            S_DECODE: begin
                // Branch target is computed here so BEQ can finish in one more cycle.
                ctrl.alusrcb    = ALUB_IMM_SH2;
                ctrl.aluop      = ALUOP_ADD;
                ctrl.illegal_op = !is_supported(opcode);
                ctrl.instr_done = !is_supported(opcode);
            end
            S_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.memtoreg   = 1'b1;
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_req    = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.memwrite   = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_RTYPE_EX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUB_RT;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_RTYPE_WB: begin
                ctrl.regdst     = 1'b1;
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BEQ: begin
                ctrl.alusrca    = 1'b1;
                ctrl.alusrcb    = ALUB_RT;
                ctrl.aluop      = ALUOP_SUB;
                ctrl.pcsrc      = PCSRC_ALUOUT;
                ctrl.pcwrite    = zero;
                ctrl.instr_done = 1'b1;
            end
            S_ADDI_EX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_ADDI_WB: begin
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl.pcsrc      = PCSRC_JUMP;
                ctrl.pcwrite    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    assign waiting = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
                     && !mem_ready;

    mc_wait_timer #(
        .MEM_WAIT_MAX (MEM_WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .waiting (waiting),
        .restart (state_d != state_q),
        .timeout (mem_timeout)
    );

    // Strobes and enables are suppressed while rst is held so nothing commits during reset.
    assign mem_req    = ctrl.mem_req    & ~rst;
    assign memwrite   = ctrl.memwrite   & ~rst;
    assign irwrite    = ctrl.irwrite    & ~rst;
    assign regwrite   = ctrl.regwrite   & ~rst;
    assign pcwrite    = ctrl.pcwrite    & ~rst;
    assign instr_done = ctrl.instr_done & ~rst;
    assign illegal_op = ctrl.illegal_op & ~rst;

    assign iord     = ctrl.iord;
    assign regdst   = ctrl.regdst;
    assign memtoreg = ctrl.memtoreg;
    assign alusrca  = ctrl.alusrca;
    assign alusrcb  = ctrl.alusrcb;
    assign aluop    = ctrl.aluop;
    assign pcsrc    = ctrl.pcsrc;
    assign state    = state_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS-subset CPU. It sequences the shared ALU, register file, single unified memory port and PC through fetch, decode, execute, memory and writeback steps. It drives the 2-bit aluop consumed by the ALU control decoder and the datapath mux selects and write enables. It waits on a memory-ready handshake and flags unsupported opcodes.

Parameters:
MEM_WAIT_MAX, 15, cycles a memory state waits for mem_ready before raising mem_timeout; range 1..255.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
opcode  input  6  instr[31:26] from the instruction register; valid from DECODE onward
zero  input  1  ALU zero flag, sampled in BEQ
mem_ready  input  1  memory completes the current request this cycle
mem_req  output  1  memory request active
iord  output  1  memory address select: 0 = PC, 1 = ALUOut
memwrite  output  1  memory write strobe
irwrite  output  1  instruction register load
regdst  output  1  write register select: 0 = rt, 1 = rd
memtoreg  output  1  write data select: 0 = ALUOut, 1 = MDR
regwrite  output  1  register file write enable
alusrca  output  1  ALU A select: 0 = PC, 1 = rs
alusrcb  output  2  ALU B select: 00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
aluop  output  2  00 = add, 10 = subtract, 01 = decode from funct
pcsrc  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
pcwrite  output  1  PC load enable, final (branch condition already folded in)
instr_done  output  1  one-cycle pulse on the last cycle of each instruction
illegal_op  output  1  one-cycle pulse when DECODE sees an unsupported opcode
mem_timeout  output  1  sticky flag; cleared only by rst
state  output  4  current state encoding, for debug

Behaviour:
- Supported opcodes: R = 000000, LW = 100011, SW = 101011, BEQ = 000100, ADDI = 001000, J = 000010.
- State register. rst high at a clock edge forces state to FETCH, clears the wait counter and clears mem_timeout.
- While rst is high, all of these are forced to 0 combinationally: mem_req, memwrite, irwrite, regwrite, pcwrite, instr_done, illegal_op.
- Outputs are Moore-decoded from state, except where a state says qualified by mem_ready or zero. Any output not listed for a state is 0.
- FETCH:
  - mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite and pcwrite are asserted only in a cycle where mem_ready=1.
  - mem_ready=1 -> DECODE; otherwise stay in FETCH.
- DECODE:
  - alusrca=0, alusrcb=11, aluop=00 (precomputes the branch target).
  - Next state: LW/SW -> MEMADR; R -> RTYPE_EX; BEQ -> BEQ; ADDI -> ADDI_EX; J -> JUMP.
  - Any other opcode -> FETCH with illegal_op=1 and instr_done=1.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. LW -> MEMRD; SW -> MEMWR.
- MEMRD: mem_req=1, iord=1. mem_ready=1 -> MEMWB; otherwise hold.
- MEMWB: regdst=0, memtoreg=1, regwrite=1, instr_done=1 -> FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=1 while waiting. mem_ready=1 -> FETCH with instr_done=1.
- RTYPE_EX: alusrca=1, alusrcb=00, aluop=01 -> RTYPE_WB.
- RTYPE_WB: regdst=1, memtoreg=0, regwrite=1, instr_done=1 -> FETCH.
- BEQ:
  - alusrca=1, alusrcb=00, aluop=10, pcsrc=01.
  - pcwrite = zero.
  - instr_done=1 -> FETCH.
- ADDI_EX: alusrca=1, alusrcb=10, aluop=00 -> ADDI_WB.
- ADDI_WB: regdst=0, memtoreg=0, regwrite=1, instr_done=1 -> FETCH.
- JUMP: pcsrc=10, pcwrite=1, instr_done=1 -> FETCH.
- Wait counter:
  - 8-bit; cleared on every state change; increments each cycle spent in FETCH, MEMRD or MEMWR with mem_ready=0.
  - On reaching MEM_WAIT_MAX, mem_timeout is set and stays set. The FSM keeps waiting; the counter saturates.
- mem_ready asserted outside FETCH, MEMRD and MEMWR is ignored.
- rst mid-instruction (including mid-wait) aborts it. No write enable is asserted in the reset cycle; FETCH begins the cycle after rst deasserts.
- Latency in cycles, with zero memory wait: LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3.

Decomposition:
- Package mc_pkg holds:
  - opcode constants;
  - state encoding (FETCH=0 .. JUMP=11);
  - aluop constants ALUOP_ADD=2'b00, ALUOP_SUB=2'b10, ALUOP_FUNCT=2'b01;
  - alusrcb and pcsrc select constants.
- One sub-module: mc_wait_timer (wait counter plus sticky timeout), instantiated once.
- Next-state logic and output decode stay in multicycle_ctrl.

Test Plan:
- rst=1 for 2 cycles, mem_ready=1 throughout: during rst all enables are 0; the first cycle after rst shows state=0, mem_req=1, irwrite=1, pcwrite=1.
- LW (opcode 100011), mem_ready always 1: state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 with memtoreg=1 in cycle 5; instr_done pulses once.
- R-type (000000): aluop=01 in RTYPE_EX; regdst=1, regwrite=1 in RTYPE_WB; total 4 cycles. ADDI (001000) gives aluop=00, alusrcb=10, regdst=0.
- BEQ (000100): with zero=1, pcwrite=1 and pcsrc=01 in cycle 3; with zero=0, pcwrite=0. J (000010): pcsrc=10, pcwrite=1 in cycle 3.
- SW (101011) with mem_ready low for 20 cycles in MEMWR, MEM_WAIT_MAX=15: memwrite is held high throughout; mem_timeout rises after 15 wait cycles and stays high; on mem_ready=1 the FSM goes to FETCH with instr_done=1.
- Opcode 111111 in DECODE: illegal_op=1 and instr_done=1 for one cycle, next state FETCH. Separately, rst asserted in MEMRD: regwrite never rises and state=FETCH after rst deasserts.
